branch_resolver: RTL

- EX-stage counterpart of the branch predictor.
- Records each prediction made at fetch in an in-order queue. When the branch resolves in EX, it compares the actual outcome against the oldest record.
- Produces the predictor feedback (feedback_valid, prediction_correct, correct_destination, branch_pc).
- On a misprediction it redirects fetch and sequences a pipeline flush.

---
 rtl/branch_resolver_if.sv | 40 ++++
 rtl/branch_resolver.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/branch_resolver_if.sv
// Fetch/EX/predictor-feedback bundle for the branch resolver.
// The slave side is the resolver; the master side drives pushes and resolves.
interface branch_resolver_if #(
  parameter int unsigned CNT_W = 16
);
  logic             pred_push_i;
  logic [31:0]      pred_pc_i;
  logic             pred_taken_i;
  logic [31:0]      pred_target_i;
  logic             stall_i;
  logic             ex_valid_i;
  logic [31:0]      ex_pc_i;
  logic             ex_taken_i;
  logic [31:0]      ex_target_i;
  logic             feedback_valid;
  logic             prediction_correct;
  logic [31:0]      correct_destination;
  logic [31:0]      branch_pc;
  logic             redirect_o;
  logic [31:0]      redirect_pc_o;
  logic             flush_o;
  logic             full_o;
  logic             err_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport master (
    output pred_push_i, pred_pc_i, pred_taken_i, pred_target_i, stall_i,
    output ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
    input  feedback_valid, prediction_correct, correct_destination, branch_pc,
    input  redirect_o, redirect_pc_o, flush_o, full_o, err_o, branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  pred_push_i, pred_pc_i, pred_taken_i, pred_target_i, stall_i,
    input  ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
    output feedback_valid, prediction_correct, correct_destination, branch_pc,
    output redirect_o, redirect_pc_o, flush_o, full_o, err_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: checks outcomes against an in-order queue of fetch
// predictions, feeds the predictor back and sequences redirect plus flush on a miss.
module branch_resolver #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  branch_resolver_if.slave  bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic {StIdle, StFlush} state_e;

  logic [31:0]      mem_pc_q    [DEPTH];
  logic             mem_taken_q [DEPTH];
  logic [31:0]      mem_tgt_q   [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;

  logic             fb_valid_q, fb_valid_d, correct_q, correct_d;
  logic [31:0]      dest_q, dest_d, bpc_q, bpc_d, rpc_q, rpc_d;
  logic             redirect_q, redirect_d, err_q, err_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

  logic        idle, resolve, empty, full, pc_ok, correct, mispred, pop, push_ok;
  logic [31:0] actual_dest;

  always_comb begin
    idle        = (state_q == StIdle);
    resolve     = idle & bus.ex_valid_i & ~bus.stall_i;
    empty       = (count_q == '0);
    full        = (count_q == FullCnt);
    pc_ok       = ~empty & (mem_pc_q[rd_ptr_q] == bus.ex_pc_i);
    correct     = pc_ok & (mem_taken_q[rd_ptr_q] == bus.ex_taken_i) &
                  (~bus.ex_taken_i | (mem_tgt_q[rd_ptr_q] == bus.ex_target_i));
    mispred     = resolve & ~correct;
    pop         = resolve & ~empty;
    // A push alongside a mispredict is wrong-path and is discarded with the queue.
    push_ok     = idle & bus.pred_push_i & (~full | pop) & ~mispred;
    actual_dest = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + 32'd4;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispred) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StIdle: begin
        if (mispred) begin
          state_d = StFlush;
          fcnt_d  = 3'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: begin
        if (fcnt_q == '0) state_d = StIdle;
        else              fcnt_d  = fcnt_q - 3'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fb_valid_d = resolve;
    correct_d  = resolve & correct;
    dest_d     = resolve ? actual_dest : dest_q;
    bpc_d      = resolve ? bus.ex_pc_i : bpc_q;
    redirect_d = mispred;
    rpc_d      = mispred ? actual_dest : rpc_q;
    err_d      = err_q | (resolve & ~pc_ok) | (idle & bus.pred_push_i & full & ~pop);
    bcnt_d     = (resolve & ~&bcnt_q) ? bcnt_q + 1'b1 : bcnt_q;
    mcnt_d     = (mispred & ~&mcnt_q) ? mcnt_q + 1'b1 : mcnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      fcnt_q     <= '0;
      fb_valid_q <= 1'b0;
      correct_q  <= 1'b0;
      dest_q     <= '0;
      bpc_q      <= '0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      err_q      <= 1'b0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      fb_valid_q <= fb_valid_d;
      correct_q  <= correct_d;
      dest_q     <= dest_d;
      bpc_q      <= bpc_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      err_q      <= err_d;
      bcnt_q     <= bcnt_d;
      mcnt_q     <= mcnt_d;
    end
  end

  // Record storage needs no reset; count_q gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_pc_q[wr_ptr_q]    <= bus.pred_pc_i;
      mem_taken_q[wr_ptr_q] <= bus.pred_taken_i;
      mem_tgt_q[wr_ptr_q]   <= bus.pred_target_i;
    end
  end

  assign bus.feedback_valid      = fb_valid_q;
  assign bus.prediction_correct  = correct_q;
  assign bus.correct_destination = dest_q;
  assign bus.branch_pc           = bpc_q;
  assign bus.redirect_o          = redirect_q;
  assign bus.redirect_pc_o       = rpc_q;
  assign bus.flush_o             = (state_q == StFlush);
  assign bus.full_o              = full;
  assign bus.err_o               = err_q;
  assign bus.branch_cnt_o        = bcnt_q;
  assign bus.mispred_cnt_o       = mcnt_q;
endmodule
